// File: rtl/config_shift_adder_4bit_if.sv
// ============================================================================
// Module      : config_shift_adder_4bit_if
// Description : Operand/result bundle for the precision-scalable 4-bit multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface config_shift_adder_4bit_if;
  logic       in_valid;
  logic [3:0] multiplier;
  logic [3:0] multiplicand;
  logic       halvedPrecision;
  logic [7:0] product;
  logic       out_valid;

  modport master (
    output in_valid, multiplier, multiplicand, halvedPrecision,
    input  product, out_valid
  );

  modport slave (
    input  in_valid, multiplier, multiplicand, halvedPrecision,
    output product, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/config_shift_adder_4bit.sv
// ============================================================================
// Module      : config_shift_adder_4bit
// Description : Shift-and-add 4x4 multiplier, optionally split into two 2x2 lanes,
//               with a registered 8-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_shift_adder_4bit #(
  parameter bit configurable = 1'b1,
  parameter bit zeroExtend   = 1'b1
) (
  input wire clk,
  input wire rst_n,
  config_shift_adder_4bit_if.slave bus
);

  logic       halved;
  logic [7:0] term [4];
  logic [7:0] full_sum;
  logic [3:0] lo_sum;
  logic [3:0] hi_sum;
  logic [7:0] product_next;
  logic [7:0] product_reg;
  logic       valid_reg;

  assign halved = configurable && bus.halvedPrecision;

  // One row per multiplier bit; in halved mode the cross-lane bits of the
  // shared partial-product array are gated off and each lane extends from its own MSB.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_row
      localparam bit LO_LANE  = (i < 2);
      localparam bit FULL_MSB = (i == 3);
      localparam bit HALF_MSB = (i == 1) || (i == 3);

      logic [3:0] keep;
      logic [3:0] pp;
      logic       sign;
      logic [7:0] ext;
      logic [7:0] shifted;
      logic       negate;

      assign keep    = !halved ? 4'b1111 : (LO_LANE ? 4'b0011 : 4'b1100);
      assign pp      = {4{bus.multiplier[i]}} & bus.multiplicand & keep;
      assign sign    = zeroExtend ? 1'b0 : ((halved && LO_LANE) ? pp[1] : pp[3]);
      assign ext     = (halved && LO_LANE) ? {{6{sign}}, pp[1:0]} : {{4{sign}}, pp};
      assign shifted = ext << i;
      assign negate  = !zeroExtend && (halved ? HALF_MSB : FULL_MSB);
      assign term[i] = negate ? (~shifted + 8'd1) : shifted;
    end
  endgenerate

  // Lane sums are kept 4 bits wide so no carry can cross the nibble boundary.
  assign full_sum = term[0] + term[1] + term[2] + term[3];
  assign lo_sum   = term[0][3:0] + term[1][3:0];
  assign hi_sum   = term[2][7:4] + term[3][7:4];

  assign product_next = halved ? {hi_sum, lo_sum} : full_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg <= 8'h00;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        product_reg <= product_next;
      end
    end
  end

  assign bus.product   = product_reg;
  assign bus.out_valid = valid_reg;

endmodule

`default_nettype wire

// File: tb/tb_config_shift_adder_4bit.sv
// ============================================================================
// Module      : tb_config_shift_adder_4bit
// Description : Directed self-checking bench for three parameterisations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_shift_adder_4bit;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  config_shift_adder_4bit_if bus_def ();
  config_shift_adder_4bit_if bus_sgn ();
  config_shift_adder_4bit_if bus_fix ();

  config_shift_adder_4bit #(.configurable(1'b1), .zeroExtend(1'b1)) u_def (
    .clk(clk), .rst_n(rst_n), .bus(bus_def.slave));
  config_shift_adder_4bit #(.configurable(1'b1), .zeroExtend(1'b0)) u_sgn (
    .clk(clk), .rst_n(rst_n), .bus(bus_sgn.slave));
  config_shift_adder_4bit #(.configurable(1'b0), .zeroExtend(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(bus_fix.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic h);
    bus_def.in_valid = v; bus_def.multiplier = a; bus_def.multiplicand = b; bus_def.halvedPrecision = h;
    bus_sgn.in_valid = v; bus_sgn.multiplier = a; bus_sgn.multiplicand = b; bus_sgn.halvedPrecision = h;
    bus_fix.in_valid = v; bus_fix.multiplier = a; bus_fix.multiplicand = b; bus_fix.halvedPrecision = h;
  endtask

  // Present one operand set for a single edge, then sample 1 time unit after it.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic h);
    @(negedge clk);
    drive(1'b1, a, b, h);
    @(posedge clk);
    #1;
    drive(1'b0, a, b, h);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    #12;
    check("reset_product", bus_def.product, 8'h00);
    check("reset_valid", {7'd0, bus_def.out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    apply(4'd3, 4'd3, 1'b1);
    check("half_3x3", bus_def.product, 8'b0000_1001);
    check("half_3x3_valid", {7'd0, bus_def.out_valid}, 8'h01);
    @(posedge clk); #1;
    check("valid_drops", {7'd0, bus_def.out_valid}, 8'h00);
    check("idle_hold", bus_def.product, 8'b0000_1001);

    apply(4'b1101, 4'b0011, 1'b1);
    check("half_m3x3_u", bus_def.product, 8'b0000_0011);
    check("half_m3x3_s", bus_sgn.product, 8'b0000_1111);

    apply(4'b1101, 4'b1101, 1'b1);
    check("half_m3xm3_u", bus_def.product, 8'b1001_0001);

    apply(4'd0, 4'd0, 1'b0);
    check("full_zero", bus_def.product, 8'h00);

    apply(4'b1011, 4'b1011, 1'b0);
    check("full_11x11_u", bus_def.product, 8'd121);
    check("full_m5xm5_s", bus_sgn.product, 8'h19);

    apply(4'b1011, 4'b1011, 1'b1);
    check("fixed_ignores_half", bus_fix.product, 8'd121);
    check("half_1011_u", bus_def.product, 8'h49);
    check("half_1011_s", bus_sgn.product, 8'h41);

    apply(4'b1111, 4'b1111, 1'b0);
    check("full_15x15_u", bus_def.product, 8'd225);
    check("full_m1xm1_s", bus_sgn.product, 8'h01);

    // Operands toggle while in_valid stays low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 4'(k + 2), 4'(k + 5), k[0]);
    end
    @(posedge clk); #1;
    check("hold_u", bus_def.product, 8'd225);
    check("hold_s", bus_sgn.product, 8'h01);

    // Reset asserted away from any clock edge while an op is being presented.
    @(negedge clk);
    drive(1'b1, 4'd7, 4'd7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_product", bus_def.product, 8'h00);
    check("async_reset_valid", {7'd0, bus_def.out_valid}, 8'h00);
    @(posedge clk); #1;
    check("reset_held_product", bus_sgn.product, 8'h00);
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    rst_n = 1'b1;

    apply(4'b0111, 4'b0011, 1'b0);
    check("post_reset_u", bus_def.product, 8'd21);
    check("post_reset_s", bus_sgn.product, 8'h15);
    check("post_reset_valid", {7'd0, bus_def.out_valid}, 8'h01);

    // Back-to-back ops with a mode change in between.
    @(negedge clk);
    drive(1'b1, 4'b1101, 4'b1101, 1'b1);
    @(posedge clk); #1;
    check("b2b_half", bus_def.product, 8'b1001_0001);
    @(negedge clk);
    drive(1'b1, 4'b1101, 4'b1101, 1'b0);
    @(posedge clk); #1;
    check("b2b_full", bus_def.product, 8'd169);
    check("b2b_full_s", bus_sgn.product, 8'h09);
    drive(1'b0, 4'd0, 4'd0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
